// File: rtl/fsmc_reg_slave.sv
// FSMC asynchronous-bus register slave.
// Pad signals are synchronised, decoded by a 3-state FSM into register writes and reads.
module fsmc_reg_slave #(
  parameter int AW    = 2,
  parameter int DW    = 16,
  parameter int NREGS = 4
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                aNE,
  input  logic                aNOE,
  input  logic                aNWE,
  input  logic [AW-1:0]       aA,
  input  logic [DW-1:0]       aD,
  output logic [DW-1:0]       d_out,
  output logic                d_oe,
  output logic [NREGS*DW-1:0] regs,
  output logic                wr_strobe,
  output logic [AW-1:0]       wr_adr
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } state_t;

  state_t state;
  state_t state_nx;

  logic          ne_m;
  logic          noe_m;
  logic          nwe_m;
  logic [AW-1:0] a_m;
  logic [DW-1:0] d_m;

  logic          sNE;
  logic          sNOE;
  logic          sNWE;
  logic [AW-1:0] sA;
  logic [DW-1:0] sD;

  logic [AW-1:0] adr_cap;
  logic [DW-1:0] dat_cap;
  logic          wr_arm;

  logic          commit;
  logic          capture;
  logic          abort;
  logic          illegal;
  logic [DW-1:0] rd_val;

  // Strobes idle high, address/data idle low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ne_m  <= 1'b1;
      noe_m <= 1'b1;
      nwe_m <= 1'b1;
      a_m   <= '0;
      d_m   <= '0;
      sNE   <= 1'b1;
      sNOE  <= 1'b1;
      sNWE  <= 1'b1;
      sA    <= '0;
      sD    <= '0;
    end else begin
      ne_m  <= aNE;
      noe_m <= aNOE;
      nwe_m <= aNWE;
      a_m   <= aA;
      d_m   <= aD;
      sNE   <= ne_m;
      sNOE  <= noe_m;
      sNWE  <= nwe_m;
      sA    <= a_m;
      sD    <= d_m;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    commit   = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    illegal  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!sNE && !sNWE && !sNOE) begin
          illegal = 1'b1;
        end else if (!sNE && !sNWE && wr_arm) begin
          state_nx = WR;
        end else if (!sNE && !sNOE && sNWE) begin
          state_nx = RD;
        end
      end
      WR: begin
        if (sNWE) begin
          commit   = 1'b1;
          state_nx = IDLE;
        end else if (sNE) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end else begin
          capture  = 1'b1;
        end
      end
      RD: begin
        if (sNOE || sNE) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A write strobe held low through an abort must be released before it counts again.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_arm <= 1'b1;
    end else if (abort || illegal) begin
      wr_arm <= 1'b0;
    end else if (sNWE) begin
      wr_arm <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      adr_cap <= '0;
      dat_cap <= '0;
    end else if (capture) begin
      adr_cap <= sA;
      dat_cap <= sD;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_strobe <= 1'b0;
      wr_adr    <= '0;
    end else begin
      wr_strobe <= commit;
      if (commit) begin
        wr_adr <= adr_cap;
      end
    end
  end

  // Out-of-range addresses match no register, so they write nothing.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      regs <= '0;
    end else if (commit) begin
      for (int i = 0; i < NREGS; i++) begin
        if (adr_cap == AW'(i)) begin
          regs[i*DW +: DW] <= dat_cap;
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (sA == AW'(i)) begin
        rd_val = regs[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      d_oe  <= 1'b0;
      d_out <= '0;
    end else if (state_nx == RD) begin
      d_oe  <= 1'b1;
      d_out <= rd_val;
    end else begin
      d_oe  <= 1'b0;
      d_out <= '0;
    end
  end

endmodule

// File: tb/tb_fsmc_reg_slave.sv
// Randomised bench for fsmc_reg_slave (NREGS=4 and NREGS=3 instances on one bus).
// Transaction-level register model; outputs checked whenever the bus has settled.
module tb_fsmc_reg_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst;
  logic        aNE;
  logic        aNOE;
  logic        aNWE;
  logic [1:0]  aA;
  logic [15:0] aD;

  logic [15:0] d_out4;
  logic        d_oe4;
  logic [63:0] regs4;
  logic        ws4;
  logic [1:0]  wa4;

  logic [15:0] d_out3;
  logic        d_oe3;
  logic [47:0] regs3;
  logic        ws3;
  logic [1:0]  wa3;

  fsmc_reg_slave #(.AW(2), .DW(16), .NREGS(4)) u4 (
    .clk(clk), .nrst(nrst), .aNE(aNE), .aNOE(aNOE), .aNWE(aNWE),
    .aA(aA), .aD(aD), .d_out(d_out4), .d_oe(d_oe4), .regs(regs4),
    .wr_strobe(ws4), .wr_adr(wa4)
  );

  fsmc_reg_slave #(.AW(2), .DW(16), .NREGS(3)) u3 (
    .clk(clk), .nrst(nrst), .aNE(aNE), .aNOE(aNOE), .aNWE(aNWE),
    .aA(aA), .aD(aD), .d_out(d_out3), .d_oe(d_oe3), .regs(regs3),
    .wr_strobe(ws3), .wr_adr(wa3)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] m4[4];
  logic [15:0] m3[4];
  logic [1:0]  madr;
  int          exp_cnt = 0;
  int          cnt4 = 0;
  int          cnt3 = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [63:0] flat4();
    logic [63:0] f;
    for (int i = 0; i < 4; i++) f[i*16 +: 16] = m4[i];
    return f;
  endfunction

  function automatic logic [47:0] flat3();
    logic [47:0] f;
    for (int i = 0; i < 3; i++) f[i*16 +: 16] = m3[i];
    return f;
  endfunction

  function automatic logic [15:0] rd3(input logic [1:0] a);
    return (a < 2'd3) ? m3[a] : 16'h0;
  endfunction

  task automatic model_write(input logic [1:0] a, input logic [15:0] d);
    m4[a] = d;
    if (a < 2'd3) m3[a] = d;
    madr = a;
    exp_cnt++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m4[i] = 16'h0;
      m3[i] = 16'h0;
    end
    madr = 2'd0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [15:0] d,
                          input int hold, input bit ne_late, input int gap);
    aA   = a;
    aD   = d;
    aNE  = 1'b0;
    aNWE = 1'b0;
    cyc(hold);
    aNWE = 1'b1;
    model_write(a, d);
    if (ne_late) cyc(1);
    aNE = 1'b1;
    cyc(gap);
  endtask

  task automatic do_read(input logic [1:0] a, input int hold,
                         input int nchg, input int gap);
    aA   = a;
    aNE  = 1'b0;
    aNOE = 1'b0;
    cyc(hold);
    repeat (nchg) begin
      aA = 2'($urandom_range(0, 3));
      cyc(hold);
    end
    aNOE = 1'b1;
    aNE  = 1'b1;
    cyc(gap);
  endtask

  // relow: chip select drops again while the write strobe is still held low.
  task automatic do_abort(input bit relow, input int gap);
    aA   = 2'($urandom_range(0, 3));
    aD   = 16'($urandom);
    aNE  = 1'b0;
    aNWE = 1'b0;
    cyc(5);
    aNE = 1'b1;
    if (relow) begin
      cyc(3);
      aNE = 1'b0;
      cyc(6);
      aNE  = 1'b1;
      aNWE = 1'b1;
    end else begin
      cyc(2);
      aNWE = 1'b1;
    end
    cyc(gap);
  endtask

  task automatic do_illegal(input int gap);
    aNE  = 1'b0;
    aNOE = 1'b0;
    aNWE = 1'b0;
    cyc(10);
    aNE  = 1'b1;
    aNOE = 1'b1;
    aNWE = 1'b1;
    cyc(gap);
  endtask

  // Settled-bus checker: after 4 quiet edges all outputs follow from the model.
  logic [21:0] cur_in;
  logic [21:0] prev_in = '1;
  int          stable = 0;
  logic        pws4 = 1'b0;
  logic        pws3 = 1'b0;
  logic        exp_oe;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cur_in = {nrst, aNE, aNOE, aNWE, aA, aD};
      if (cur_in !== prev_in) stable = 1;
      else stable++;
      prev_in = cur_in;
      if (ws4 === 1'b1) cnt4++;
      if (ws3 === 1'b1) cnt3++;
      chk("strobe_width", 64'({ws4 & pws4, ws3 & pws3}), 64'd0);
      pws4 = ws4;
      pws3 = ws3;
      if (stable >= 4) begin
        exp_oe = nrst && !aNE && !aNOE && aNWE;
        chk("d_oe4", 64'(d_oe4), 64'(exp_oe));
        chk("d_oe3", 64'(d_oe3), 64'(exp_oe));
        chk("d_out4", 64'(d_out4), exp_oe ? 64'(m4[aA]) : 64'd0);
        chk("d_out3", 64'(d_out3), exp_oe ? 64'(rd3(aA)) : 64'd0);
        chk("regs4", regs4, flat4());
        chk("regs3", 64'(regs3), 64'(flat3()));
        chk("wr_adr4", 64'(wa4), 64'(madr));
        chk("wr_adr3", 64'(wa3), 64'(madr));
        chk("strobes4", 64'(cnt4), 64'(exp_cnt));
        chk("strobes3", 64'(cnt3), 64'(exp_cnt));
      end
    end
  end

  int c;
  int r;

  initial begin
    model_reset();
    nrst = 1'b0;
    aNE  = 1'b1;
    aNOE = 1'b1;
    aNWE = 1'b1;
    aA   = 2'd0;
    aD   = 16'h0;
    cyc(3);
    chk("rst_regs", regs4, 64'd0);
    chk("rst_oe", 64'({d_oe4, d_oe3}), 64'd0);
    chk("rst_dout", 64'(d_out4), 64'd0);
    chk("rst_adr", 64'(wa4), 64'd0);
    chk("rst_strobe", 64'(ws4), 64'd0);
    nrst = 1'b1;
    cyc(4);

    // Pad edge to d_oe: two synchroniser edges plus the state edge.
    aA   = 2'd0;
    aNE  = 1'b0;
    aNOE = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("lat_2", 64'(d_oe4), 64'd0);
    @(posedge clk);
    #1 chk("lat_3", 64'(d_oe4), 64'd1);
    #1;
    cyc(3);
    aNOE = 1'b1;
    aNE  = 1'b1;
    cyc(5);

    c = cnt4;
    do_write(2'd2, 16'hA5A5, 5, 1'b0, 5);
    chk("wb_strobes", 64'(cnt4 - c), 64'd1);
    chk("wb_adr", 64'(wa4), 64'd2);
    chk("wb_regs", regs4, 64'h0000_A5A5_0000_0000);
    aA   = 2'd2;
    aNE  = 1'b0;
    aNOE = 1'b0;
    cyc(5);
    chk("wb_oe", 64'(d_oe4), 64'd1);
    chk("wb_dout", 64'(d_out4), 64'hA5A5);
    aNOE = 1'b1;
    aNE  = 1'b1;
    cyc(5);

    c = cnt3;
    do_write(2'd3, 16'h1234, 4, 1'b1, 5);
    chk("oor_strobes", 64'(cnt3 - c), 64'd1);
    chk("oor_adr", 64'(wa3), 64'd3);
    chk("oor_regs3", 64'(regs3), 64'hA5A5_0000_0000);
    chk("oor_regs4", 64'(regs4[63:48]), 64'h1234);
    aA   = 2'd3;
    aNE  = 1'b0;
    aNOE = 1'b0;
    cyc(5);
    chk("oor_oe", 64'(d_oe3), 64'd1);
    chk("oor_dout3", 64'(d_out3), 64'd0);
    chk("oor_dout4", 64'(d_out4), 64'h1234);
    aNOE = 1'b1;
    aNE  = 1'b1;
    cyc(5);

    c = cnt4;
    do_abort(1'b0, 5);
    do_abort(1'b1, 5);
    do_illegal(5);
    chk("abort_strobes", 64'(cnt4 - c), 64'd0);
    chk("abort_regs", regs4, 64'h1234_A5A5_0000_0000);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        do_write(2'($urandom_range(0, 3)), 16'($urandom),
                 $urandom_range(3, 8), 1'($urandom_range(0, 1)),
                 $urandom_range(1, 6));
      end else if (r < 7) begin
        do_read(2'($urandom_range(0, 3)), $urandom_range(2, 7),
                $urandom_range(0, 3), $urandom_range(1, 6));
      end else if (r == 7) begin
        do_abort(1'b0, $urandom_range(1, 6));
      end else if (r == 8) begin
        do_abort(1'b1, $urandom_range(1, 6));
      end else begin
        do_illegal($urandom_range(1, 6));
      end
    end
    cyc(6);

    aA   = 2'd1;
    aNE  = 1'b0;
    aNOE = 1'b0;
    cyc(5);
    chk("rr_oe_before", 64'(d_oe4), 64'd1);
    nrst = 1'b0;
    model_reset();
    #1;
    chk("rr_oe", 64'({d_oe4, d_oe3}), 64'd0);
    chk("rr_dout", 64'(d_out4), 64'd0);
    chk("rr_regs4", regs4, 64'd0);
    chk("rr_regs3", 64'(regs3), 64'd0);
    aNE  = 1'b1;
    aNOE = 1'b1;
    cyc(2);
    nrst = 1'b1;
    cyc(3);
    do_write(2'd0, 16'h0001, 4, 1'b0, 6);
    chk("rr_write", 64'(regs4[15:0]), 64'd1);

    c = cnt4;
    do_write(2'd0, 16'd1, 4, 1'b0, 1);
    do_write(2'd1, 16'd2, 4, 1'b0, 1);
    do_write(2'd2, 16'd3, 4, 1'b0, 1);
    do_write(2'd3, 16'd4, 4, 1'b0, 6);
    chk("b2b_strobes", 64'(cnt4 - c), 64'd4);
    chk("b2b_regs4", regs4, 64'h0004_0003_0002_0001);
    chk("b2b_regs3", 64'(regs3), 64'h0003_0002_0001);
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsmc_reg_slave.md
FSMC_REG_SLAVE -- requirements
Module: fsmc_reg_slave

Interface
REQ-001 Parameter AW, default 2: width of the FSMC address field, in bits.
REQ-002 Parameter DW, default 16: data bus width, in bits.
REQ-003 Parameter NREGS, default 4: number of registers; legal range 1..2**AW.
REQ-004 clk  in  1  system clock, the single clock of the block.
REQ-005 nrst  in  1  reset, asynchronous assert, active-low.
REQ-006 aNE  in  1  asynchronous chip select, active-low.
REQ-007 aNOE  in  1  asynchronous output enable (read strobe), active-low.
REQ-008 aNWE  in  1  asynchronous write enable (write strobe), active-low.
REQ-009 aA  in  AW  asynchronous register address.
REQ-010 aD  in  DW  asynchronous write data from the bus.
REQ-011 d_out  out  DW  read data to the bus pad driver.
REQ-012 d_oe  out  1  pad output enable: high means drive d_out onto the bus.
REQ-013 regs  out  NREGS*DW  all register contents; register i occupies bits [i*DW +: DW].
REQ-014 wr_strobe  out  1  one-cycle pulse on each committed write.
REQ-015 wr_adr  out  AW  address of the last committed write.

Function
REQ-016 Each of aNE, aNOE, aNWE, aA and aD SHALL pass through its own 2-flop synchroniser on clk before any use; these synchronised versions are sNE, sNOE, sNWE, sA and sD.
REQ-017 The FSM SHALL have three states: IDLE, WR and RD.
REQ-018 IDLE -> WR SHALL occur when sNE=0, sNWE=0 and sNOE=1.
REQ-019 IDLE -> RD SHALL occur when sNE=0, sNOE=0 and sNWE=1.
REQ-020 In IDLE, sNWE=0 together with sNOE=0 is illegal; the FSM SHALL stay in IDLE with no side effects.
REQ-021 In WR, each cycle with sNWE=0 SHALL capture sA into adr_cap and sD into dat_cap.
REQ-022 In WR, the first cycle with sNWE=1 SHALL commit the write:
- regs[adr_cap] <= dat_cap
- wr_strobe=1 for exactly 1 cycle
- wr_adr <= adr_cap
- next state IDLE
REQ-023 Commit SHALL still occur when sNWE and sNE both return to 1 in the same cycle.
REQ-024 In WR, sNE=1 while sNWE=0 SHALL abort: no register change, no wr_strobe, next state IDLE.
REQ-025 A write with adr_cap >= NREGS SHALL commit no register, but SHALL still pulse wr_strobe and update wr_adr.
REQ-026 In RD, d_oe SHALL be 1 and d_out SHALL be registered each cycle from regs[sA], so address changes are tracked.
REQ-027 In RD, reads with sA >= NREGS SHALL return 0.
REQ-028 RD -> IDLE SHALL occur when sNOE=1 or sNE=1; d_oe SHALL be 0 and d_out SHALL be 0 from the cycle IDLE is entered.
REQ-029 Outside RD, d_oe SHALL be 0 and d_out SHALL be 0.
REQ-030 After IDLE, a new access SHALL require a fresh qualifying strobe; a strobe held low across an abort SHALL NOT re-enter WR until sNWE has been seen high.
REQ-031 Latency from a pad edge to the resulting FSM state change SHALL be 2 clk cycles (synchroniser) plus 1 cycle (state register).
REQ-032 Register updates SHALL be visible on regs the cycle after commit.
REQ-033 A read issued in the cycle after a commit SHALL return the new value.

Reset
REQ-034 nrst=0 SHALL immediately, without waiting for clk, set:
- FSM to IDLE
- all registers, regs, d_out, wr_adr, adr_cap and dat_cap to 0
- d_oe and wr_strobe to 0
REQ-035 Synchroniser flops SHALL reset to 1 for aNE, aNOE and aNWE, and to 0 for aA and aD.
REQ-036 Reset asserted mid-write SHALL discard the write; reset asserted mid-read SHALL deassert d_oe immediately.
REQ-037 Operation SHALL resume on the first clk edge after nrst returns to 1.

Verification
REQ-038 Write then read back: AW=2, DW=16, NREGS=4. Write 0xA5A5 to address 2, then read address 2 -> wr_strobe pulses once, wr_adr=2, regs[47:32]=0xA5A5, d_out=0xA5A5 while d_oe=1, and all other registers stay 0.
REQ-039 Out-of-range access: NREGS=3. Write 0x1234 to address 3 -> regs unchanged and wr_strobe pulses; then read address 3 -> d_out=0x0000 with d_oe=1.
REQ-040 Abort: aNE rises 2 cycles before aNWE rises -> no register change and no wr_strobe; the FSM returns to IDLE.
REQ-041 Illegal strobes: aNOE=0 and aNWE=0 together with aNE=0 for 10 cycles -> d_oe stays 0, no wr_strobe, regs unchanged.
REQ-042 Reset mid-read: nrst pulled low during RD with d_oe=1 -> d_oe=0 and regs=0 before the next clk edge; after release, a write of 0x0001 to address 0 gives regs[15:0]=0x0001.
REQ-043 Back-to-back writes: addresses 0,1,2,3 with data 1,2,3,4 and 1 idle bus cycle between each -> exactly 4 wr_strobe pulses and regs={4,3,2,1}.
